// File: rtl/life_step_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module      : life_step_engine_pkg
// Description : Shared types and helpers for the Game-of-Life step engine.
//               WORD_SIZE / LOG_MAX_ADDR size the board word and address
//               buses; life_state_t is the engine's control state.
// Revision    : 1.0  initial release
// ============================================================================
package life_step_engine_pkg;

  localparam int WORD_SIZE    = 32;
  localparam int LOG_MAX_ADDR = 15;

  typedef logic [WORD_SIZE-1:0]    data_t;
  typedef logic [LOG_MAX_ADDR-1:0] addr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    SWAP  = 2'd3
  } life_state_t;

  // Conway rule: birth on exactly 3 neighbours, survival on 2 or 3.
  function automatic logic life_rule(input logic alive, input logic [3:0] n);
    return (n == 4'd3) || (alive && (n == 4'd2));
  endfunction

endpackage
`default_nettype wire

// File: rtl/life_step_engine_word_next.sv
`default_nettype none
// ============================================================================
// Module      : life_word_next
// Description : Combinational next-generation for one board word. Takes a
//               3x3 window of words (row 0 = row above, column 0 = word to
//               the left) and returns the next state of the centre word.
// Ports       : i_win   3x3 data_t window, [row][col]
//               o_next  next generation of i_win[1][1]
// Revision    : 1.0  initial release
// ============================================================================
module life_word_next
  import life_step_engine_pkg::*;
(
  input  data_t i_win [3][3],
  output data_t o_next
);

  // Each row is widened by one cell on each side so that every centre bit
  // sees its left/right neighbours at fixed offsets: ext[i] is the left
  // neighbour of cell i, ext[i+1] the cell itself, ext[i+2] the right one.
  logic [WORD_SIZE+1:0] w_ext_up;
  logic [WORD_SIZE+1:0] w_ext_mid;
  logic [WORD_SIZE+1:0] w_ext_dn;

  assign w_ext_up  = {i_win[0][2][0], i_win[0][1], i_win[0][0][WORD_SIZE-1]};
  assign w_ext_mid = {i_win[1][2][0], i_win[1][1], i_win[1][0][WORD_SIZE-1]};
  assign w_ext_dn  = {i_win[2][2][0], i_win[2][1], i_win[2][0][WORD_SIZE-1]};

  for (genvar gi = 0; gi < WORD_SIZE; gi++) begin : g_bit
    logic [3:0] w_cnt;
    assign w_cnt = 4'(w_ext_up[gi])  + 4'(w_ext_up[gi+1])  + 4'(w_ext_up[gi+2])
                 + 4'(w_ext_mid[gi])                       + 4'(w_ext_mid[gi+2])
                 + 4'(w_ext_dn[gi])  + 4'(w_ext_dn[gi+1])  + 4'(w_ext_dn[gi+2]);
    assign o_next[gi] = life_rule(w_ext_mid[gi+1], w_cnt);
  end

endmodule
`default_nettype wire

// File: rtl/life_step_engine.sv
`default_nettype none
// ============================================================================
// Module      : life_step_engine
// Description : Computes one Game-of-Life generation per accepted step. Reads
//               the current board through the double buffer's logic read
//               port, writes the next board through its write port, then
//               pulses swap. Cells outside the board are dead.
// Ports       : clk_130mhz    system clock
//               rst_in        synchronous active-high reset
//               step_in       generation request (level, sampled in IDLE)
//               buf_ready_in  double buffer ready
//               rd_data_in    read data, READ_LATENCY after rd_addr_out
//               rd_addr_out   read address (held when no read is issued)
//               wr_addr_out   write address
//               wr_data_out   write data
//               wr_en_out     write strobe, one cycle per board word
//               swap_out      buffer swap pulse after the last write
//               busy_out      high from accept until done_out
//               done_out      one-cycle pulse the cycle after swap_out
// Revision    : 1.0  initial release
// ============================================================================
module life_step_engine
  import life_step_engine_pkg::*;
#(
  parameter int BOARD_WORDS_X = 32,
  parameter int BOARD_ROWS    = 768,
  parameter int READ_LATENCY  = 2
) (
  input  logic  clk_130mhz,
  input  logic  rst_in,
  input  logic  step_in,
  input  logic  buf_ready_in,
  input  data_t rd_data_in,
  output addr_t rd_addr_out,
  output addr_t wr_addr_out,
  output data_t wr_data_out,
  output logic  wr_en_out,
  output logic  swap_out,
  output logic  busy_out,
  output logic  done_out
);

  localparam int COL_W   = $clog2(BOARD_WORDS_X + 1);
  localparam int ROW_W   = $clog2(BOARD_ROWS + 1);
  localparam int DRAIN_W = $clog2(READ_LATENCY + 1);

  // --------------------------------------------------------------------------
  // Control state. r_row/r_col/r_ph name the read slot presented on
  // rd_addr_out during the current cycle; the virtual column BOARD_WORDS_X
  // flushes a zero right-hand word through the window at every row end.
  // --------------------------------------------------------------------------
  life_state_t         r_state;
  logic [ROW_W-1:0]    r_row;
  logic [COL_W-1:0]    r_col;
  logic [1:0]          r_ph;
  logic [DRAIN_W-1:0]  r_drain;

  logic                w_accept;
  logic                w_last;
  logic                w_issue;
  logic [ROW_W-1:0]    w_n_row;
  logic [COL_W-1:0]    w_n_col;
  logic [1:0]          w_n_ph;
  logic [ROW_W:0]      w_rr_ext;
  logic [ROW_W:0]      w_rd_row;
  logic                w_rd_ok;
  addr_t               w_rd_addr;

  assign w_accept = (r_state == IDLE) && step_in && buf_ready_in;
  assign w_last   = (r_state == RUN)
                 && (r_row == ROW_W'(BOARD_ROWS - 1))
                 && (r_col == COL_W'(BOARD_WORDS_X))
                 && (r_ph  == 2'd2);
  // A slot is issued on accept (slot 0,0,0) and on every RUN cycle but the last.
  assign w_issue  = w_accept || ((r_state == RUN) && !w_last);

  // Next read slot; stays at zero outside RUN so counters never overrun.
  always_comb begin
    w_n_row = '0;
    w_n_col = '0;
    w_n_ph  = '0;
    if ((r_state == RUN) && !w_last) begin
      w_n_row = r_row;
      w_n_col = r_col;
      w_n_ph  = r_ph + 2'd1;
      if (r_ph == 2'd2) begin
        w_n_ph = '0;
        if (r_col == COL_W'(BOARD_WORDS_X)) begin
          w_n_col = '0;
          w_n_row = r_row + ROW_W'(1);
        end else begin
          w_n_col = r_col + COL_W'(1);
        end
      end
    end
  end

  // Phase p reads board row (row + p - 1); kept offset by one so that the
  // row above row 0 is simply ext value 0 rather than a negative number.
  assign w_rr_ext  = {1'b0, w_n_row} + (ROW_W+1)'(w_n_ph);
  assign w_rd_row  = w_rr_ext - (ROW_W+1)'(1);
  assign w_rd_ok   = w_issue
                  && (w_rr_ext != '0)
                  && (w_rr_ext <= (ROW_W+1)'(BOARD_ROWS))
                  && (w_n_col < COL_W'(BOARD_WORDS_X));
  assign w_rd_addr = addr_t'(w_rd_row) * addr_t'(BOARD_WORDS_X) + addr_t'(w_n_col);

  // --------------------------------------------------------------------------
  // FSM with registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_130mhz) begin
    if (rst_in) begin
      r_state  <= IDLE;
      r_row    <= '0;
      r_col    <= '0;
      r_ph     <= '0;
      r_drain  <= '0;
      swap_out <= 1'b0;
      busy_out <= 1'b0;
      done_out <= 1'b0;
    end else begin
      r_row    <= w_n_row;
      r_col    <= w_n_col;
      r_ph     <= w_n_ph;
      swap_out <= 1'b0;
      done_out <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state  <= RUN;
            busy_out <= 1'b1;
          end
        end
        RUN: begin
          if (w_last) begin
            r_state <= DRAIN;
            r_drain <= '0;
          end
        end
        DRAIN: begin
          // READ_LATENCY+1 cycles: the final slot's data lands and its
          // registered write completes before swap goes out.
          if (r_drain == DRAIN_W'(READ_LATENCY)) begin
            r_state  <= SWAP;
            swap_out <= 1'b1;
          end else begin
            r_drain <= r_drain + DRAIN_W'(1);
          end
        end
        SWAP: begin
          r_state  <= IDLE;
          busy_out <= 1'b0;
          done_out <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Read-tag pipeline: stage 0 is aligned with rd_addr_out, stage
  // READ_LATENCY with the matching rd_data_in.
  // --------------------------------------------------------------------------
  logic             r_tag_v   [READ_LATENCY+1];
  logic             r_tag_rd  [READ_LATENCY+1];
  logic [1:0]       r_tag_ph  [READ_LATENCY+1];
  logic [COL_W-1:0] r_tag_col [READ_LATENCY+1];
  logic [ROW_W-1:0] r_tag_row [READ_LATENCY+1];

  always_ff @(posedge clk_130mhz) begin
    if (rst_in) begin
      rd_addr_out <= '0;
      for (int i = 0; i <= READ_LATENCY; i++) begin
        r_tag_v[i]   <= 1'b0;
        r_tag_rd[i]  <= 1'b0;
        r_tag_ph[i]  <= '0;
        r_tag_col[i] <= '0;
        r_tag_row[i] <= '0;
      end
    end else begin
      if (w_rd_ok) begin
        rd_addr_out <= w_rd_addr;
      end
      r_tag_v[0]   <= w_issue;
      r_tag_rd[0]  <= w_rd_ok;
      r_tag_ph[0]  <= w_n_ph;
      r_tag_col[0] <= w_n_col;
      r_tag_row[0] <= w_n_row;
      for (int i = 1; i <= READ_LATENCY; i++) begin
        r_tag_v[i]   <= r_tag_v[i-1];
        r_tag_rd[i]  <= r_tag_rd[i-1];
        r_tag_ph[i]  <= r_tag_ph[i-1];
        r_tag_col[i] <= r_tag_col[i-1];
        r_tag_row[i] <= r_tag_row[i-1];
      end
    end
  end

  // --------------------------------------------------------------------------
  // 3x3 window. Phase 0 of every slot shifts all rows left; each phase then
  // fills its row's right-hand word. When phase 2 lands, the window (with
  // the arriving word patched in) covers columns c-2..c and column c-1 is
  // written out.
  // --------------------------------------------------------------------------
  logic       w_land_v;
  logic [1:0] w_land_ph;
  data_t      w_word;
  data_t      r_win [3][3];
  data_t      w_win [3][3];
  data_t      w_next;
  logic       w_wr;

  assign w_land_v  = r_tag_v[READ_LATENCY];
  assign w_land_ph = r_tag_ph[READ_LATENCY];
  assign w_word    = r_tag_rd[READ_LATENCY] ? rd_data_in : '0;
  assign w_wr      = w_land_v && (w_land_ph == 2'd2)
                  && (r_tag_col[READ_LATENCY] != '0);

  always_comb begin
    w_win       = r_win;
    w_win[2][2] = w_word;
  end

  life_word_next u_word_next (
    .i_win  (w_win),
    .o_next (w_next)
  );

  always_ff @(posedge clk_130mhz) begin
    if (rst_in) begin
      for (int k = 0; k < 3; k++) begin
        for (int j = 0; j < 3; j++) begin
          r_win[k][j] <= '0;
        end
      end
    end else if (w_land_v) begin
      case (w_land_ph)
        2'd0: begin
          for (int k = 0; k < 3; k++) begin
            r_win[k][0] <= r_win[k][1];
            r_win[k][1] <= r_win[k][2];
          end
          r_win[0][2] <= w_word;
        end
        2'd1:    r_win[1][2] <= w_word;
        default: r_win[2][2] <= w_word;
      endcase
    end
  end

  always_ff @(posedge clk_130mhz) begin
    if (rst_in) begin
      wr_en_out   <= 1'b0;
      wr_addr_out <= '0;
      wr_data_out <= '0;
    end else begin
      wr_en_out <= w_wr;
      if (w_wr) begin
        wr_addr_out <= addr_t'(r_tag_row[READ_LATENCY]) * addr_t'(BOARD_WORDS_X)
                     + addr_t'(r_tag_col[READ_LATENCY]) - addr_t'(1);
        wr_data_out <= w_next;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_life_step_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_life_step_engine
// Description : Scoreboard bench for life_step_engine on a 2-word x 4-row
//               board with a behavioural double buffer.
// Revision    : 1.0  initial release
// ============================================================================
module tb_life_step_engine;
  import life_step_engine_pkg::*;

  localparam int BWX     = 2;
  localparam int ROWS    = 4;
  localparam int RL      = 2;
  localparam int NWORDS  = BWX * ROWS;
  localparam int GEN_LEN = ROWS * (BWX + 1) * 3 + RL + 3;

  logic  clk_130mhz = 1'b0;
  logic  rst_in;
  logic  step_in;
  logic  buf_ready_in;
  data_t rd_data_in;
  addr_t rd_addr_out;
  addr_t wr_addr_out;
  data_t wr_data_out;
  logic  wr_en_out;
  logic  swap_out;
  logic  busy_out;
  logic  done_out;

  always #4 clk_130mhz = ~clk_130mhz;

  life_step_engine #(
    .BOARD_WORDS_X (BWX),
    .BOARD_ROWS    (ROWS),
    .READ_LATENCY  (RL)
  ) dut (
    .clk_130mhz   (clk_130mhz),
    .rst_in       (rst_in),
    .step_in      (step_in),
    .buf_ready_in (buf_ready_in),
    .rd_data_in   (rd_data_in),
    .rd_addr_out  (rd_addr_out),
    .wr_addr_out  (wr_addr_out),
    .wr_data_out  (wr_data_out),
    .wr_en_out    (wr_en_out),
    .swap_out     (swap_out),
    .busy_out     (busy_out),
    .done_out     (done_out)
  );

  // Behavioural double buffer: two-stage read pipe, writes go to the back
  // board, swap copies back to front.
  data_t cur      [NWORDS];
  data_t nxt      [NWORDS];
  data_t load_img [NWORDS];
  logic  tb_load = 1'b0;
  data_t d1, d2;
  int    cyc = 0;

  assign rd_data_in = d2;

  always @(posedge clk_130mhz) begin
    cyc <= cyc + 1;
    d1  <= cur[rd_addr_out[2:0]];
    d2  <= d1;
    if (wr_en_out) nxt[wr_addr_out[2:0]] <= wr_data_out;
    if (tb_load) cur <= load_img;
    else if (swap_out) cur <= nxt;
  end

  // Scoreboard
  logic [LOG_MAX_ADDR+WORD_SIZE-1:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int swap_cnt = 0;
  int last_wr_cyc = -1;
  int swap_cyc = -1;
  int done_cyc = -1;

  initial begin
    logic [LOG_MAX_ADDR+WORD_SIZE-1:0] e;
    forever begin
      @(negedge clk_130mhz);
      if (wr_en_out === 1'b1) begin
        wr_cnt++;
        last_wr_cyc = cyc;
        checks++;
        if (wr_addr_out >= addr_t'(NWORDS)) begin
          errors++;
          $display("FAIL wr_addr_range: got %0d, need < %0d", wr_addr_out, NWORDS);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: addr %0d data %h, nothing expected",
                   wr_addr_out, wr_data_out);
        end else begin
          e = exp_q.pop_front();
          if ({wr_addr_out, wr_data_out} !== e) begin
            errors++;
            $display("FAIL write_word: got addr %0d data %h, need addr %0d data %h",
                     wr_addr_out, wr_data_out, e[LOG_MAX_ADDR+WORD_SIZE-1:WORD_SIZE],
                     e[WORD_SIZE-1:0]);
          end
        end
      end
      if (swap_out === 1'b1) begin
        swap_cnt++;
        swap_cyc = cyc;
      end
      if (done_out === 1'b1) done_cyc = cyc;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, need %0d", name, act, req);
    end
  endtask

  task automatic load_board(input data_t img [NWORDS]);
    @(negedge clk_130mhz);
    load_img = img;
    tb_load  = 1'b1;
    @(negedge clk_130mhz);
    tb_load  = 1'b0;
  endtask

  task automatic push_exp(input data_t img [NWORDS]);
    for (int a = 0; a < NWORDS; a++) exp_q.push_back({addr_t'(a), img[a]});
  endtask

  // One generation: step for one cycle (or held until done), then check
  // length, write count, swap/done ordering and that the scoreboard drained.
  task automatic run_gen(input string name, input bit hold);
    int  len;
    int  s0;
    int  w0;
    bit  seen;
    s0 = swap_cnt;
    w0 = wr_cnt;
    @(negedge clk_130mhz);
    step_in = 1'b1;
    @(negedge clk_130mhz);
    if (!hold) step_in = 1'b0;
    len  = 0;
    seen = 1'b0;
    for (int k = 0; k < GEN_LEN + 20 && !seen; k++) begin
      if (busy_out || done_out) len++;
      if (done_out) seen = 1'b1;
      else @(negedge clk_130mhz);
    end
    step_in = 1'b0;
    #1;
    chk({name, "_done_seen"}, 64'(seen), 64'd1);
    chk({name, "_gen_len"}, 64'(len), 64'(GEN_LEN));
    chk({name, "_swaps"}, 64'(swap_cnt - s0), 64'd1);
    chk({name, "_writes"}, 64'(wr_cnt - w0), 64'(NWORDS));
    chk({name, "_swap_after_wr"}, 64'(swap_cyc > last_wr_cyc), 64'd1);
    chk({name, "_done_after_swap"}, 64'(done_cyc - swap_cyc), 64'd1);
    chk({name, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    data_t img [NWORDS];
    data_t ex  [NWORDS];
    int    s0;
    int    w0;
    int    nb;
    rst_in       = 1'b1;
    step_in      = 1'b0;
    buf_ready_in = 1'b1;
    repeat (3) @(negedge clk_130mhz);
    chk("reset_outputs",
        64'({rd_addr_out, wr_addr_out, wr_data_out, wr_en_out, swap_out, busy_out, done_out}),
        64'd0);
    rst_in = 1'b0;

    // 1: empty board stays empty
    img = '{default: '0};
    load_board(img);
    push_exp(img);
    run_gen("empty", 1'b0);

    // 2: horizontal blinker flips to vertical and back
    img = '{0, 0, 32'h38, 0, 0, 0, 0, 0};
    ex  = '{32'h10, 0, 32'h10, 0, 32'h10, 0, 0, 0};
    load_board(img);
    push_exp(ex);
    run_gen("blinker1", 1'b0);
    push_exp(img);
    run_gen("blinker2", 1'b0);

    // 3: blinker across the word boundary
    img = '{0, 0, 32'h8000_0000, 32'h3, 0, 0, 0, 0};
    ex  = '{0, 32'h1, 0, 32'h1, 0, 32'h1, 0, 0};
    load_board(img);
    push_exp(ex);
    run_gen("straddle", 1'b0);

    // 4: block on the top/left edge is stable
    img = '{32'h3, 0, 32'h3, 0, 0, 0, 0, 0};
    load_board(img);
    push_exp(img);
    run_gen("block", 1'b0);

    // 5: reset in the middle of RUN aborts the generation
    push_exp(img);
    s0 = swap_cnt;
    w0 = wr_cnt;
    @(negedge clk_130mhz);
    step_in = 1'b1;
    @(negedge clk_130mhz);
    step_in = 1'b0;
    for (int k = 0; k < GEN_LEN && (wr_cnt - w0) < 3; k++) @(negedge clk_130mhz);
    chk("abort_reached_writes", 64'(wr_cnt - w0 >= 3), 64'd1);
    rst_in = 1'b1;
    @(negedge clk_130mhz);
    chk("abort_wr_en", 64'(wr_en_out), 64'd0);
    chk("abort_busy", 64'(busy_out), 64'd0);
    exp_q.delete();
    w0 = wr_cnt;
    rst_in = 1'b0;
    repeat (GEN_LEN + 10) @(negedge clk_130mhz);
    chk("abort_no_swap", 64'(swap_cnt - s0), 64'd0);
    chk("abort_no_writes", 64'(wr_cnt - w0), 64'd0);

    // 6a: step held through a generation gives exactly one
    push_exp(img);
    run_gen("held", 1'b1);
    nb = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_130mhz);
      if (busy_out) nb++;
    end
    chk("held_no_restart", 64'(nb), 64'd0);

    // 6b: step while the buffer is not ready is ignored
    s0 = swap_cnt;
    buf_ready_in = 1'b0;
    step_in      = 1'b1;
    nb = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_130mhz);
      if (busy_out) nb++;
    end
    step_in      = 1'b0;
    buf_ready_in = 1'b1;
    chk("notready_busy", 64'(nb), 64'd0);
    chk("notready_swap", 64'(swap_cnt - s0), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
